// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM state encoding, channel constants and default sample width.
// Both the receiver and the transmitter use this package.
package i2s_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t HUNT = 2'd0;
  localparam state_t SYNC = 2'd1;
  localparam state_t RUN  = 2'd2;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_if.sv
// Pin-side I2S lines plus the decoded sample outputs of the receiver.
// The slave modport is the receiver; the master modport is the ADC/consumer side.
interface i2s_rx_if import i2s_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             i2s_bck;
  logic             i2s_lrck;
  logic             i2s_data;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             sample_valid;
  logic             locked;

  modport master (
    output i2s_bck, i2s_lrck, i2s_data,
    input  left, right, sample_valid, locked
  );

  modport slave (
    input  i2s_bck, i2s_lrck, i2s_data,
    output left, right, sample_valid, locked
  );
endinterface

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for BCK/LRCK/DATA plus a registered BCK rising-edge strobe.
// o_lrck/o_data are the values sampled alongside the rise, valid while o_rise is high.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bck,
  input  logic i_lrck,
  input  logic i_data,
  output logic o_rise,
  output logic o_lrck,
  output logic o_data
);
  logic [SYNC_STAGES-1:0] r_bck_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_bck_prev;
  logic                   r_rise;
  logic                   r_lrck;
  logic                   r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bck_sync  <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bck_prev  <= 1'b0;
      r_rise      <= 1'b0;
      r_lrck      <= 1'b0;
      r_data      <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[SYNC_STAGES-2:0], i_bck};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_lrck};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
      r_bck_prev  <= r_bck_sync[SYNC_STAGES-1];
      // All three lanes share the same depth, so DATA/LRCK line up with the detected rise.
      r_rise      <= r_bck_sync[SYNC_STAGES-1] & ~r_bck_prev;
      r_lrck      <= r_lrck_sync[SYNC_STAGES-1];
      r_data      <= r_data_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_rise;
  assign o_lrck = r_lrck;
  assign o_data = r_data;
endmodule

// File: rtl/i2s_rx.sv
// Slave-mode Philips I2S receiver: deserialises stereo words and strobes a left/right pair.
// Optional BCK-loss watchdog is compiled in with I2S_RX_WATCHDOG_EN.
module i2s_rx import i2s_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int WD_CYCLES   = 4096
) (
  input logic     clk,
  input logic     rst,
  i2s_rx_if.slave i2s
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (SYNC_STAGES < 2 || WD_CYCLES < 2) begin : g_param_check
    $error("i2s_rx: SYNC_STAGES and WD_CYCLES must both be at least 2");
  end

  logic w_rise;
  logic w_lrck;
  logic w_data;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_bck  (i2s.i2s_bck),
    .i_lrck (i2s.i2s_lrck),
    .i_data (i2s.i2s_data),
    .o_rise (w_rise),
    .o_lrck (w_lrck),
    .o_data (w_data)
  );

  // Deserialiser: one accumulator reused for every slot, handed off at each LRCK edge.
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lrck_prev;
  logic             r_word_vld;
  logic             r_word_ch;
  logic [WIDTH-1:0] r_word_dat;
  logic [WIDTH-1:0] w_word;
  logic             w_boundary;

  assign w_boundary = w_rise && (w_lrck != r_lrck_prev);

  always_comb begin
    w_word = r_acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == CNT_W'(WIDTH - 1 - i)) w_word[i] = w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_lrck_prev <= 1'b0;
      r_word_vld  <= 1'b0;
      r_word_ch   <= 1'b0;
      r_word_dat  <= '0;
    end else begin
      r_word_vld <= 1'b0;
      if (w_rise) begin
        r_lrck_prev <= w_lrck;
        if (w_boundary) begin
          // Philips framing: the boundary bit is the LSB of the word that is ending.
          r_word_vld <= 1'b1;
          r_word_ch  <= r_lrck_prev;
          r_word_dat <= w_word;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc <= w_word;
          if (r_cnt != CNT_W'(WIDTH)) r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  logic w_wd_timeout;

`ifdef I2S_RX_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES);
  logic [WD_W-1:0] r_wd_cnt;

  // A rise in the timeout cycle wins: the counter restarts and no timeout is raised.
  assign w_wd_timeout = !w_rise && (r_wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_wd_cnt <= '0;
    else if (w_rise)       r_wd_cnt <= '0;
    else if (!w_wd_timeout) r_wd_cnt <= r_wd_cnt + 1'b1;
  end
`else
  assign w_wd_timeout = 1'b0;
`endif

  // Framing FSM.
  state_t r_state;
  state_t w_state_nxt;
  logic   w_hold_ld;
  logic   w_out_ld;
  logic   w_locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_word_vld) begin
      case (r_state)
        HUNT:    w_state_nxt = SYNC;
        SYNC:    if (r_word_ch == CH_LEFT) w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end
    if (w_wd_timeout) w_state_nxt = HUNT;
  end

  always_comb begin
    w_locked  = (r_state == RUN);
    w_hold_ld = r_word_vld && (r_word_ch == CH_LEFT) && (r_state != HUNT);
    w_out_ld  = r_word_vld && (r_word_ch == CH_RIGHT) && (r_state == RUN) && !w_wd_timeout;
  end

  // Output stage: left word waits in r_hold until its right partner completes.
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_left;
  logic [WIDTH-1:0] r_right;
  logic             r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
    end else if (w_wd_timeout) begin
      r_hold  <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_out_ld;
      if (w_hold_ld) r_hold <= r_word_dat;
      if (w_out_ld) begin
        r_left  <= r_hold;
        r_right <= r_word_dat;
      end
    end
  end

  assign i2s.left         = r_left;
  assign i2s.right        = r_right;
  assign i2s.sample_valid = r_valid;
  assign i2s.locked       = w_locked;
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Slave-mode I2S receiver for the audio input path of the menu/board top level. It samples externally driven BCK/LRCK/DATA from an I2S ADC, which are asynchronous to the system clock. It deserialises Philips-format stereo words and presents a left/right sample pair with a single-cycle valid strobe. It is the receive counterpart of the I2S transmitter that drives I2S_BCK/I2S_LRCK/I2S_DATA toward the DAC.

## Interface
- WIDTH, 16: output sample width; bits beyond WIDTH in a slot are dropped.
- SYNC_STAGES, 2: synchroniser depth for the three I2S inputs; minimum 2.
- WD_CYCLES, 4096: CLK cycles without a BCK rise before lock is dropped. Used only with the watchdog enabled.
- CLK  in  1  system clock, at least 4x the BCK frequency.
- RESET  in  1  reset, asynchronous, active-high.
- I2S_BCK  in  1  bit clock, asynchronous to CLK.
- I2S_LRCK  in  1  word select; 0 = left, 1 = right.
- I2S_DATA  in  1  serial data, MSB first.
- LEFT  out  WIDTH  last complete left sample.
- RIGHT  out  WIDTH  last complete right sample.
- SAMPLE_VALID  out  1  one-CLK pulse when LEFT/RIGHT update.
- LOCKED  out  1  high while in RUN.

## Operation
- Synchronisation:
  - BCK, LRCK and DATA each pass through SYNC_STAGES flops.
  - A BCK rise is detected when the synchronised BCK goes 0 to 1.
  - All logic below acts only on cycles that carry a BCK rise.
- Per BCK rise, sample d = DATA and l = LRCK.
- A word boundary occurs when l differs from the LRCK value stored at the previous rise.
- Philips framing: the bit sampled at a boundary rise is the LSB of the word that is ending.
- Bit placement:
  - Each word has an accumulator that is cleared at word start and a bit counter cnt that saturates at WIDTH.
  - While cnt < WIDTH, d is written to bit WIDTH-1-cnt.
  - Slots shorter than WIDTH are therefore left-aligned with zero LSBs; longer slots are truncated.
- At a boundary rise:
  - Place d into the ending word.
  - Hand the ending word off by channel: a left word goes to a left hold register, a right word goes to the output stage.
  - Clear the accumulator and set cnt to 0.
- State machine:
  - HUNT → SYNC on the first boundary. The partial word before it is discarded.
  - SYNC → RUN at the end of the first complete left word (LRCK 0 to 1 boundary).
  - In SYNC, a right→left boundary updates nothing.
  - In RUN, each right→left boundary (LRCK 1 to 0) loads LEFT from the left hold register and RIGHT from the ending word, and pulses SAMPLE_VALID.
  - RUN persists until RESET or a watchdog timeout.
- Reset values: LEFT=0, RIGHT=0, SAMPLE_VALID=0, LOCKED=0, state HUNT, all internal registers 0.
- RESET asserted mid-word aborts immediately. After release, the block re-enters HUNT and discards the first partial word.

## Timing
- Latency: SAMPLE_VALID and the new LEFT/RIGHT appear SYNC_STAGES+2 CLK cycles after the CLK edge that first captures the BCK rise at the pin.
- LEFT and RIGHT change only in the SAMPLE_VALID cycle and hold otherwise.
- SAMPLE_VALID is exactly one CLK wide. The minimum spacing between pulses is one full LRCK period.
- LOCKED rises in the same cycle the state enters RUN and falls in the cycle it leaves RUN.
- The CLK ≥ 4×BCK requirement guarantees each BCK high and low phase is seen by at least two synchronised samples.

## Configuration
- I2S_RX_WATCHDOG_EN defined:
  - A counter counts CLK cycles since the last BCK rise.
  - Reaching WD_CYCLES forces HUNT, LOCKED=0, LEFT=RIGHT=0, and SAMPLE_VALID is suppressed.
  - If a BCK rise occurs in the same cycle as the timeout, the rise wins and the counter resets.
- I2S_RX_WATCHDOG_EN undefined: no counter is present, and LOCKED falls only on RESET.

## Structure
- Shared package i2s_pkg:
  - state encoding localparams HUNT/SYNC/RUN;
  - channel constants CH_LEFT=0, CH_RIGHT=1;
  - default WIDTH.
  - The transmitter uses the same channel constants.
- Sub-module i2s_rx_sync: a parameterised SYNC_STAGES synchroniser for the three inputs, plus the BCK rising-edge detector.

## Test plan
- Lock and capture: CLK 48 MHz, BCK 3.072 MHz, 32-bit slots, left=16'h1234, right=16'hABCD repeated. Required: LOCKED rises after the first full left word; every frame gives SAMPLE_VALID with LEFT=16'h1234, RIGHT=16'hABCD.
- Short slots: 12-bit slots with WIDTH=16, left=12'hFFF. Required: LEFT=16'hFFF0.
- Truncation: 24-bit slots, right=24'h89ABCD. Required: RIGHT=16'h89AB.
- Mid-word start: stimulus begins mid-right word. Required: no SAMPLE_VALID until a complete left/right pair; the first pulse carries correct data.
- Reset mid-frame: RESET asserted at bit 7 of a left word. Required: all outputs are 0 immediately; after release, the block relocks and the first pulse has correct data.
- Watchdog (macro defined, WD_CYCLES=4096): stop BCK while in RUN. Required: LOCKED=0 and LEFT=RIGHT=0 exactly 4096 cycles after the last BCK rise; on restarting BCK, the block relocks.
